jc_tsg_param: RTL and testbench

Parametrised Johnson-counter timing sequence generator. A STAGES-bit Johnson counter is decoded into 2*STAGES one-hot timing signals. The block adds enable/hold, a one-shot burst mode with start and done, synchronous clear, a binary phase output, and illegal-state detection with self-recovery. It drives phase-sequenced control in datapath and controller blocks.

---
 rtl/jc_tsg_param.sv | 127 ++++++++++++
 tb/tb_jc_tsg_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jc_tsg_param.sv
// Johnson-counter timing sequence generator: STAGES-bit Johnson counter decoded
// into 2*STAGES one-hot timing strobes, with enable, one-shot burst, sync clear,
// binary phase output and sticky illegal-state detection with self-recovery.
module jc_tsg_param #(
    parameter int STAGES = 4,
    parameter int PW     = $clog2(2 * STAGES)
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  sync_clear,
    output logic [2*STAGES-1:0]   T,
    output logic [PW-1:0]         phase,
    output logic                  busy,
    output logic                  cycle_done,
    output logic                  err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [STAGES-1:0]   q, q_next;
    logic [STAGES-1:0]   shifted;
    logic [2*STAGES-1:0] dec;
    logic                legal;
    logic                at_last;
    logic                done_next;
    logic                err_next;
    int unsigned         ones;
    int unsigned         flips;

    assign shifted = {q[STAGES-2:0], ~q[STAGES-1]};
    assign busy    = (state == RUN);
    assign at_last = (phase == PW'(2 * STAGES - 1));

    // Classify the current code: count ones and adjacent bit flips, derive phase.
    always_comb begin
        ones  = 0;
        flips = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            ones = ones + 32'(q[i]);
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (q[i] != q[i-1]) flips = flips + 1;
        end
        legal = (flips <= 1);
        // Rising half (k=1..S) has Q[0]=1 and k ones; falling half has Q[0]=0
        // and S+zeros = 2S-ones.
        if (!legal || ones == 0) begin
            phase = '0;
        end else if (q[0]) begin
            phase = PW'(ones);
        end else begin
            phase = PW'(2 * STAGES - ones);
        end
    end

    // One-hot decode of the Johnson code, gated by mode/busy and legality.
    always_comb begin
        dec         = '0;
        dec[0]      = ~q[STAGES-1] & ~q[0];
        dec[STAGES] =  q[STAGES-1] &  q[0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            dec[k]          =  q[k-1] & ~q[k];
            dec[STAGES + k] = ~q[k-1] &  q[k];
        end
        T = ((!mode || busy) && legal) ? dec : '0;
    end

    // Next-state logic: clear > illegal recovery > advance (continuous, burst, drain).
    always_comb begin
        q_next     = q;
        state_next = state;
        done_next  = 1'b0;
        err_next   = err;
        if (sync_clear) begin
            q_next     = '0;
            state_next = IDLE;
            err_next   = 1'b0;
        end else if (!legal) begin
            q_next     = '0;
            state_next = IDLE;
            err_next   = 1'b1;
        end else if (!mode) begin
            state_next = IDLE;
            if (enable) begin
                q_next    = shifted;
                done_next = at_last;
            end
        end else if (state == RUN) begin
            if (enable) begin
                q_next    = shifted;
                done_next = at_last;
                if (at_last) state_next = IDLE;
            end
        end else if (q != '0) begin
            // Drain: left non-zero by a switch out of continuous mode.
            if (enable) begin
                q_next    = shifted;
                done_next = at_last;
            end
        end else if (start && enable) begin
            state_next = RUN;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            q          <= '0;
            state      <= IDLE;
            cycle_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            q          <= q_next;
            state      <= state_next;
            cycle_done <= done_next;
            err        <= err_next;
        end
    end

endmodule

// File: tb/tb_jc_tsg_param.sv
module tb_jc_tsg_param;

    logic clk;
    logic async_reset;
    logic enable;
    logic mode;
    logic start;
    logic sync_clear;

    logic [7:0]  t4;
    logic [2:0]  ph4;
    logic        busy4, done4, err4;
    logic [5:0]  t3;
    logic [2:0]  ph3;
    logic        busy3, done3, err3;
    logic [11:0] t6;
    logic [3:0]  ph6;
    logic        busy6, done6, err6;

    int checks;
    int failures;

    jc_tsg_param #(.STAGES(4)) d4 (
        .clk(clk), .async_reset(async_reset), .enable(enable), .mode(mode),
        .start(start), .sync_clear(sync_clear), .T(t4), .phase(ph4),
        .busy(busy4), .cycle_done(done4), .err(err4)
    );

    jc_tsg_param #(.STAGES(3)) d3 (
        .clk(clk), .async_reset(async_reset), .enable(enable), .mode(mode),
        .start(start), .sync_clear(sync_clear), .T(t3), .phase(ph3),
        .busy(busy3), .cycle_done(done3), .err(err3)
    );

    jc_tsg_param #(.STAGES(6)) d6 (
        .clk(clk), .async_reset(async_reset), .enable(enable), .mode(mode),
        .start(start), .sync_clear(sync_clear), .T(t6), .phase(ph6),
        .busy(busy6), .cycle_done(done6), .err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        async_reset = 1'b1;
        enable      = 1'b0;
        mode        = 1'b0;
        start       = 1'b0;
        sync_clear  = 1'b0;
        #12;
        check("rst_t_m0", 32'(t4), 32'h01);
        check("rst_phase", 32'(ph4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_err", 32'(err4), 32'd0);
        mode = 1'b1;
        #1;
        check("rst_t_m1", 32'(t4), 32'h00);
        mode = 1'b0;
        async_reset = 1'b0;
        enable = 1'b1;

        // continuous mode, 20 cycles
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("cont_t", 32'(t4), 32'(1) << (i % 8));
            check("cont_phase", 32'(ph4), 32'(i % 8));
            check("cont_done", 32'(done4), 32'((i % 8) == 0));
        end

        // enable hold at phase 3
        async_reset = 1'b1;
        #1;
        async_reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pre_hold_phase", 32'(ph4), 32'd3);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_t", 32'(t4), 32'h08);
            check("hold_phase", 32'(ph4), 32'd3);
            check("hold_done", 32'(done4), 32'd0);
        end
        enable = 1'b1;
        tick();
        check("resume_phase", 32'(ph4), 32'd4);
        check("resume_t", 32'(t4), 32'h10);

        // switch to burst mode at phase 5: drain with T gated, start ignored
        tick();
        check("pre_drain_phase", 32'(ph4), 32'd5);
        mode  = 1'b1;
        start = 1'b1;
        #1;
        check("drain_t_gated", 32'(t4), 32'h00);
        tick();
        check("drain_p6", 32'(ph4), 32'd6);
        check("drain_t6", 32'(t4), 32'h00);
        check("drain_busy6", 32'(busy4), 32'd0);
        tick();
        check("drain_p7", 32'(ph4), 32'd7);
        check("drain_busy7", 32'(busy4), 32'd0);
        tick();
        check("drain_wrap_phase", 32'(ph4), 32'd0);
        check("drain_wrap_done", 32'(done4), 32'd1);
        check("drain_wrap_busy", 32'(busy4), 32'd0);
        check("drain_wrap_t", 32'(t4), 32'h00);

        // start now accepted: burst of 8 with a retrigger attempt mid-run
        tick();
        check("burst_busy0", 32'(busy4), 32'd1);
        check("burst_t0", 32'(t4), 32'h01);
        check("burst_done0", 32'(done4), 32'd0);
        for (int k = 1; k < 8; k++) begin
            start = (k == 3);
            tick();
            check("burst_t", 32'(t4), 32'(1) << k);
            check("burst_busy", 32'(busy4), 32'd1);
            check("burst_done", 32'(done4), 32'd0);
        end
        start = 1'b0;
        tick();
        check("burst_end_t", 32'(t4), 32'h00);
        check("burst_end_busy", 32'(busy4), 32'd0);
        check("burst_end_done", 32'(done4), 32'd1);
        check("burst_end_phase", 32'(ph4), 32'd0);
        tick();
        check("idle_t", 32'(t4), 32'h00);
        check("idle_done", 32'(done4), 32'd0);
        check("idle_busy", 32'(busy4), 32'd0);

        // illegal code: gated immediately, recovered at next edge, err sticky
        mode = 1'b0;
        tick();
        check("pre_illegal_phase", 32'(ph4), 32'd1);
        enable = 1'b0;
        force d4.q = 4'b0101;
        #1;
        check("illegal_t", 32'(t4), 32'h00);
        check("illegal_phase", 32'(ph4), 32'd0);
        check("illegal_err_pre", 32'(err4), 32'd0);
        tick();
        check("illegal_err_set", 32'(err4), 32'd1);
        release d4.q;
        tick();
        check("recover_phase", 32'(ph4), 32'd0);
        check("recover_t", 32'(t4), 32'h01);
        check("recover_err", 32'(err4), 32'd1);
        check("recover_done", 32'(done4), 32'd0);
        enable = 1'b1;
        tick();
        check("err_sticky", 32'(err4), 32'd1);
        check("err_run_phase", 32'(ph4), 32'd1);
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        check("clear_err", 32'(err4), 32'd0);
        check("clear_phase", 32'(ph4), 32'd0);
        check("clear_t", 32'(t4), 32'h01);

        // S=3 and S=6 rotation in continuous mode, then async reset mid-run
        async_reset = 1'b1;
        #1;
        async_reset = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("s3_t", 32'(t3), 32'(1) << (i % 6));
            check("s3_phase", 32'(ph3), 32'(i % 6));
            check("s6_t", 32'(t6), 32'(1) << (i % 12));
            check("s6_phase", 32'(ph6), 32'(i % 12));
        end
        check("s6_done_wrap", 32'(done6), 32'd0);
        #2;
        async_reset = 1'b1;
        #1;
        check("s3_arst_phase", 32'(ph3), 32'd0);
        check("s6_arst_phase", 32'(ph6), 32'd0);
        check("s3_arst_t", 32'(t3), 32'h01);
        check("s6_arst_t", 32'(t6), 32'h001);
        async_reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
